pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the write-enable and synchronous-flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles three events: load-use hazards, taken branches resolved in MEM from the EX/MEM zero flag, and multi-cycle data-memory waits.
- Includes a memory-wait watchdog.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_detect.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller
// and the hazard/forwarding logic that sits beside it.
package pipeline_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        POST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle of hazard inputs and stage control outputs.
// master = datapath side, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    import pipeline_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic             exmem_branch;
    logic             exmem_zero;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    state_t           dbg_state;

    // No valid/ready handshake here: every input is a level sampled each
    // cycle, and each control output is valid in the same cycle.
    modport master (
        output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt,
               exmem_branch, exmem_zero, mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, mem_timeout, stall_count,
               flush_count, dbg_state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt,
               exmem_branch, exmem_zero, mem_req, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, mem_timeout, stall_count,
               flush_count, dbg_state
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the ID/EX load and the
// IF/ID consumer; register 0 never hazards.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    output logic             load_use
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (idex_rt == id_rs);
        rt_match = id_uses_rt && (idex_rt == id_rt);
        load_use = idex_memread && (idex_rt != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory-wait watchdog.
// Define PIPELINE_HAZARD_PERF_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            state;
    logic              run_ok;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;
    logic              load_use_raw;
    logic              do_freeze;
    logic              do_flush;
    logic              do_bubble;

    hazard_detect u_hazard_detect (
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_uses_rt   (bus.id_uses_rt),
        .idex_memread (bus.idex_memread),
        .idex_rt      (bus.idex_rt),
        .load_use     (load_use_raw)
    );

    // run_ok holds every control low from reset until the first clean edge.
    always_comb begin
        do_freeze = run_ok && bus.mem_req && !bus.mem_ready;
        do_flush  = run_ok && !do_freeze && bus.exmem_branch && bus.exmem_zero;
        do_bubble = run_ok && !do_freeze && !do_flush && load_use_raw &&
                    (state != POST_FLUSH);
    end

    always_comb begin
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_en     = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_en    = 1'b0;
        bus.exmem_flush = 1'b0;
        if (run_ok && !do_freeze) begin
            if (do_flush) begin
                bus.pc_en       = 1'b1;
                bus.ifid_en     = 1'b1;
                bus.idex_en     = 1'b1;
                bus.exmem_en    = 1'b1;
                bus.ifid_flush  = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_flush = 1'b1;
            end else if (do_bubble) begin
                bus.idex_en    = 1'b1;
                bus.idex_flush = 1'b1;
                bus.exmem_en   = 1'b1;
            end else begin
                bus.pc_en    = 1'b1;
                bus.ifid_en  = 1'b1;
                bus.idex_en  = 1'b1;
                bus.exmem_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            run_ok    <= 1'b0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (!run_ok) begin
            run_ok <= 1'b1;
        end else if (do_freeze) begin
            state <= MEM_WAIT;
            if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt + 1'b1 == WAIT_MAX) begin
                    timeout_q <= 1'b1;
                end
            end
        end else begin
            state    <= do_flush ? POST_FLUSH : RUN;
            wait_cnt <= '0;
        end
    end

    assign bus.mem_timeout = timeout_q;
    assign bus.dbg_state   = state;

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((do_freeze || do_bubble) && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (do_flush && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign bus.stall_count = stall_q;
    assign bus.flush_count = flush_q;
`else
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, zero register, branch
// flush, memory wait, watchdog and asynchronous reset.
module tb_pipeline_hazard_ctrl;
    import pipeline_ctrl_pkg::*;

`ifdef PIPELINE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush}
    localparam logic [6:0] CTL_OFF = 7'b000_0000;
    localparam logic [6:0] CTL_RUN = 7'b110_1010;
    localparam logic [6:0] CTL_BR  = 7'b111_1111;
    localparam logic [6:0] CTL_LU  = 7'b000_1110;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] ctl;
    assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                  bus.idex_flush, bus.exmem_en, bus.exmem_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pc(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    task automatic idle();
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_uses_rt   = 1'b0;
        bus.idex_memread = 1'b0;
        bus.idex_rt      = '0;
        bus.exmem_branch = 1'b0;
        bus.exmem_zero   = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu5();
        bus.idex_memread = 1'b1;
        bus.idex_rt      = 5'd5;
        bus.id_rs        = 5'd5;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        idle();
        #2;
        check("rst_ctl", 32'(ctl), 32'(CTL_OFF));
        check("rst_state", 32'(bus.dbg_state), 32'(RUN));
        check("rst_timeout", 32'(bus.mem_timeout), 32'd0);
        check("rst_stall", 32'(bus.stall_count), 32'd0);
        check("rst_flush", 32'(bus.flush_count), 32'd0);
        #10 reset = 1'b1;
        #1 check("pre_edge_ctl", 32'(ctl), 32'(CTL_OFF));
        tick();
        #2 check("idle_ctl", 32'(ctl), 32'(CTL_RUN));

        // load-use on rs: one bubble, then free flow
        set_lu5();
        #2 check("lu_rs_ctl", 32'(ctl), 32'(CTL_LU));
        tick();
        idle();
        #2 check("lu_rs_after", 32'(ctl), 32'(CTL_RUN));
        check("lu_stall", 32'(bus.stall_count), pc(1));

        // register zero never hazards
        bus.idex_memread = 1'b1;
        #2 check("zero_ctl", 32'(ctl), 32'(CTL_RUN));
        tick();
        check("zero_stall", 32'(bus.stall_count), pc(1));

        // rt match only counts when the consumer reads rt
        bus.idex_rt = 5'd7;
        bus.id_rt   = 5'd7;
        bus.id_rs   = 5'd3;
        #2 check("rt_unused_ctl", 32'(ctl), 32'(CTL_RUN));
        bus.id_uses_rt = 1'b1;
        #1 check("rt_used_ctl", 32'(ctl), 32'(CTL_LU));
        tick();
        idle();
        check("rt_stall", 32'(bus.stall_count), pc(2));

        // branch not taken
        bus.exmem_branch = 1'b1;
        #2 check("br_nt_ctl", 32'(ctl), 32'(CTL_RUN));
        tick();

        // taken branch beats a simultaneous load-use
        bus.exmem_zero = 1'b1;
        set_lu5();
        #2 check("br_lu_ctl", 32'(ctl), 32'(CTL_BR));
        tick();
        check("br_state", 32'(bus.dbg_state), 32'(POST_FLUSH));
        check("br_flush_cnt", 32'(bus.flush_count), pc(1));
        bus.exmem_branch = 1'b0;
        bus.exmem_zero   = 1'b0;
        #2 check("pf_lu_ctl", 32'(ctl), 32'(CTL_RUN));
        tick();
        check("pf_state", 32'(bus.dbg_state), 32'(RUN));
        check("pf_stall", 32'(bus.stall_count), pc(2));
        #2 check("run_lu_ctl", 32'(ctl), 32'(CTL_LU));
        tick();
        idle();
        check("run_lu_stall", 32'(bus.stall_count), pc(3));

        // three-cycle memory wait, branch ignored while frozen
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.exmem_branch = 1'b1;
                bus.exmem_zero   = 1'b1;
            end
            #2 check("mw_ctl", 32'(ctl), 32'(CTL_OFF));
            tick();
            bus.exmem_branch = 1'b0;
            bus.exmem_zero   = 1'b0;
            check("mw_state", 32'(bus.dbg_state), 32'(MEM_WAIT));
        end
        check("mw_timeout", 32'(bus.mem_timeout), 32'd0);
        bus.mem_ready = 1'b1;
        #2 check("mw_release_ctl", 32'(ctl), 32'(CTL_RUN));
        tick();
        check("mw_exit_state", 32'(bus.dbg_state), 32'(RUN));
        check("mw_stall", 32'(bus.stall_count), pc(6));
        check("mw_flush_cnt", 32'(bus.flush_count), pc(1));
        check("mw_exit_timeout", 32'(bus.mem_timeout), 32'd0);

        // watchdog at MEM_TIMEOUT=4
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("wd_timeout", 32'(bus.mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
        end
        bus.mem_ready = 1'b1;
        tick();
        check("wd_sticky", 32'(bus.mem_timeout), 32'd1);
        check("wd_stall", 32'(bus.stall_count), pc(12));
        bus.mem_req   = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("wd_sticky_idle", 32'(bus.mem_timeout), 32'd1);

        // asynchronous reset in the middle of a memory wait
        bus.mem_req = 1'b1;
        tick();
        tick();
        check("ar_pre_state", 32'(bus.dbg_state), 32'(MEM_WAIT));
        #4 reset = 1'b0;
        #1;
        check("ar_state", 32'(bus.dbg_state), 32'(RUN));
        check("ar_ctl", 32'(ctl), 32'(CTL_OFF));
        check("ar_timeout", 32'(bus.mem_timeout), 32'd0);
        check("ar_stall", 32'(bus.stall_count), 32'd0);
        check("ar_flush", 32'(bus.flush_count), 32'd0);
        idle();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("ar_rel_ctl", 32'(ctl), 32'(CTL_OFF));
        tick();
        #2 check("ar_run_ctl", 32'(ctl), 32'(CTL_RUN));
        set_lu5();
        #2 check("ar_lu_ctl", 32'(ctl), 32'(CTL_LU));
        tick();
        idle();
        check("ar_lu_stall", 32'(bus.stall_count), pc(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
